alu_exec_unit: RTL

//  Registered execute stage; generalised successor of the combinational ALU top level.

---
 rtl/alu_exec_pkg.sv | 44 ++++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the registered ALU execute stage.
// Decode field positions, ALU control codes, M-extension funct3 codes, FSM states.
package alu_exec_pkg;

    localparam int T_R = 6;
    localparam int T_I = 5;
    localparam int T_L = 4;
    localparam int T_S = 3;
    localparam int T_J = 2;
    localparam int T_B = 1;
    localparam int T_U = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_ctrl_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle.
// Operates on magnitudes; the sign of the selected result half is fixed on the final step.
module alu_muldiv_iter
    import alu_exec_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [2:0]   funct3_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] result_o
);

    localparam int CW = $clog2(W) + 1;

    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q;
    logic           div_q, sel_q, neg_q;

    logic [1:0]     sgn;
    logic           a_neg, b_neg, s_div, s_sel, s_neg;
    logic [W-1:0]   a_mag, b_mag, word;
    logic [W:0]     sum, r_sh, diff;
    logic [2*W-1:0] prod;

    always_comb begin
        sgn = 2'b00;
        unique case (funct3_i)
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: sgn = 2'b00;
            F3_MULH, F3_DIV, F3_REM:            sgn = 2'b11;
            F3_MULHSU:                          sgn = 2'b10;
            default:                            sgn = 2'b00;
        endcase
        a_neg = sgn[1] & a_i[W-1];
        b_neg = sgn[0] & b_i[W-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        s_div = funct3_i[2];
        s_sel = s_div ? funct3_i[1] : (funct3_i != F3_MUL);
        // Divide-by-zero keeps the all-ones quotient unsigned-looking.
        if (!s_div)
            s_neg = a_neg ^ b_neg;
        else if (funct3_i[1])
            s_neg = a_neg;
        else
            s_neg = (a_neg ^ b_neg) & (b_i != '0);
    end

    always_comb begin
        sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        r_sh = {acc_q[2*W-1:W], acc_q[W-1]};
        diff = r_sh - {1'b0, opnd_q};
        if (div_q)
            acc_d = {diff[W] ? r_sh[W-1:0] : diff[W-1:0],
                     acc_q[W-2:0], ~diff[W]};
        else
            acc_d = {sum, acc_q[W-1:1]};
        prod = neg_q ? -acc_d : acc_d;
        word = sel_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
        if (div_q)
            result_o = neg_q ? -word : word;
        else
            result_o = sel_q ? prod[2*W-1:W] : prod[W-1:0];
    end

    assign done_o = (cnt_q == CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            sel_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else if (start_i) begin
            cnt_q <= CW'(W);
            div_q <= s_div;
            sel_q <= s_sel;
            neg_q <= s_neg;
            if (s_div) begin
                acc_q  <= {{W{1'b0}}, a_mag};
                opnd_q <= b_mag;
            end else begin
                acc_q  <= {{W{1'b0}}, b_mag};
                opnd_q <= a_mag;
            end
        end else if (cnt_q != '0) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: operand select, base RV32I ALU, optional iterative M-extension.
// valid/ready on both sides; result held while the consumer stalls.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] PC_IN,
    input  logic [DATA_WIDTH-1:0] RS1_IN,
    input  logic [DATA_WIDTH-1:0] RS2_IN,
    input  logic [DATA_WIDTH-1:0] IMM_IN,
    input  logic [6:0]            OPCODE,
    input  logic [2:0]            FUNCT3,
    input  logic [6:0]            FUNCT7,
    input  logic [6:0]            TYPES,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] ALU_OUT,
    output logic                  BUSY
);

    localparam int SW = $clog2(DATA_WIDTH);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] alu_q, op_a, op_b, base_res, md_res;
    logic [3:0]            ctrl;
    logic [SW-1:0]         shamt;
    logic                  alt, force_add, is_m, accept, md_done;
    logic                  unused_opcode;

    assign unused_opcode = ^{OPCODE[6], OPCODE[4:0]};

    assign IN_READY  = (state_q == S_IDLE) | ((state_q == S_DONE) & OUT_READY);
    assign OUT_VALID = (state_q == S_DONE);
    assign BUSY      = (state_q == S_MUL) | (state_q == S_DIV);
    assign ALU_OUT   = alu_q;
    assign accept    = IN_VALID & IN_READY;
    assign is_m      = ENABLE_M & TYPES[T_R] & (FUNCT7 == FUNCT7_MULDIV);

    always_comb begin
        op_a = RS1_IN;
        if (TYPES[T_U] & OPCODE[5])
            op_a = '0;
        else if ((TYPES[T_J] & ~TYPES[T_I]) | TYPES[T_B] | TYPES[T_U])
            op_a = PC_IN;
        op_b = TYPES[T_R] ? RS2_IN : IMM_IN;
        // funct7[5] only selects SUB/SRA (R-type) or SRAI.
        alt = FUNCT7[5] &
              ((TYPES[T_R] & ((FUNCT3 == 3'b000) | (FUNCT3 == 3'b101))) |
               (TYPES[T_I] & (FUNCT3 == 3'b101)));
        force_add = TYPES[T_L] | TYPES[T_S] | TYPES[T_J] | TYPES[T_U];
        ctrl  = force_add ? ALU_ADD : {FUNCT3, alt};
        shamt = op_b[SW-1:0];
    end

    always_comb begin
        base_res = '0;
        case (ctrl)
            ALU_ADD:  base_res = op_a + op_b;
            ALU_SUB:  base_res = op_a - op_b;
            ALU_SLL:  base_res = op_a << shamt;
            ALU_SLT:  base_res = {{(DATA_WIDTH-1){1'b0}},
                                  $signed(op_a) < $signed(op_b)};
            ALU_SLTU: base_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
            ALU_XOR:  base_res = op_a ^ op_b;
            ALU_SRL:  base_res = op_a >> shamt;
            ALU_SRA:  base_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   base_res = op_a | op_b;
            ALU_AND:  base_res = op_a & op_b;
            default:  base_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .W(DATA_WIDTH)
    ) u_muldiv (
        .clk_i    (CLK),
        .rst_i    (RST | FLUSH),
        .start_i  (accept & is_m),
        .funct3_i (FUNCT3),
        .a_i      (op_a),
        .b_i      (op_b),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_ff @(posedge CLK) begin
        if (RST | FLUSH) begin
            state_q <= S_IDLE;
            alu_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_m) begin
                            state_q <= FUNCT3[2] ? S_DIV : S_MUL;
                        end else begin
                            state_q <= S_DONE;
                            alu_q   <= base_res;
                        end
                    end else if ((state_q == S_DONE) & OUT_READY) begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    if (md_done) begin
                        state_q <= S_DONE;
                        alu_q   <= md_res;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
